// File: rtl/register_file_8x16_bit_pkg.sv
// rtl/register_file_8x16_bit_pkg.sv - shared sizes and register names for the register file
package register_file_8x16_bit_pkg;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 16;

    localparam logic [ADDR_W-1:0] REG_R0 = 3'd0;
    localparam logic [ADDR_W-1:0] REG_R1 = 3'd1;
    localparam logic [ADDR_W-1:0] REG_R2 = 3'd2;
    localparam logic [ADDR_W-1:0] REG_R3 = 3'd3;
    localparam logic [ADDR_W-1:0] REG_R4 = 3'd4;
    localparam logic [ADDR_W-1:0] REG_R5 = 3'd5;
    localparam logic [ADDR_W-1:0] REG_R6 = 3'd6;
    localparam logic [ADDR_W-1:0] REG_R7 = 3'd7;

endpackage

// File: rtl/multiplexer_8_to_1_16_bit.sv
// rtl/multiplexer_8_to_1_16_bit.sv - 8-to-1 16-bit selector used for each register read port
module multiplexer_8_to_1_16_bit
    import register_file_8x16_bit_pkg::*;
(
    input  logic [DATA_W-1:0] I0,
    input  logic [DATA_W-1:0] I1,
    input  logic [DATA_W-1:0] I2,
    input  logic [DATA_W-1:0] I3,
    input  logic [DATA_W-1:0] I4,
    input  logic [DATA_W-1:0] I5,
    input  logic [DATA_W-1:0] I6,
    input  logic [DATA_W-1:0] I7,
    input  logic              S2,
    input  logic              S1,
    input  logic              S0,
    output logic [DATA_W-1:0] Y
);

    logic [ADDR_W-1:0] w_sel;

    assign w_sel = {S2, S1, S0};

    // Pick one of the eight inputs by the 3-bit select
    always_comb begin
        Y = I0;
        case (w_sel)
            REG_R0: Y = I0;
            REG_R1: Y = I1;
            REG_R2: Y = I2;
            REG_R3: Y = I3;
            REG_R4: Y = I4;
            REG_R5: Y = I5;
            REG_R6: Y = I6;
            REG_R7: Y = I7;
            default: Y = I0;
        endcase
    end

endmodule

// File: rtl/register_file_8x16_bit.sv
// rtl/register_file_8x16_bit.sv - 8x16 register file, one write port, two combinational read ports
module register_file_8x16_bit
    import register_file_8x16_bit_pkg::*;
#(
    parameter bit                R0_ZERO       = 1'b1,
    parameter bit                WRITE_THROUGH = 1'b0,
    parameter logic [DATA_W-1:0] RESET_VALUE   = 16'h0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] R0,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    output logic [DATA_W-1:0] R3,
    output logic [DATA_W-1:0] R4,
    output logic [DATA_W-1:0] R5,
    output logic [DATA_W-1:0] R6,
    output logic [DATA_W-1:0] R7
);

    // R0 comes out of reset as zero when it is hardwired, otherwise like every other register
    localparam logic [DATA_W-1:0] R0_RESET = R0_ZERO ? '0 : RESET_VALUE;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_wr_dec;
    logic [DATA_W-1:0]   w_rd1_raw;
    logic [DATA_W-1:0]   w_rd2_raw;
    logic                w_byp1;
    logic                w_byp2;

    // One-hot write decode; a write aimed at a hardwired R0 never reaches storage
    always_comb begin
        w_wr_dec = '0;
        if (WE) begin
            w_wr_dec[WA] = 1'b1;
        end
        if (R0_ZERO) begin
            w_wr_dec[REG_R0] = 1'b0;
        end
    end

    // Register storage; reset dominates any write on the same edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_regs[REG_R0] <= R0_RESET;
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_dec[i]) begin
                    r_regs[i] <= WD;
                end
            end
        end
    end

    assign R0 = r_regs[REG_R0];
    assign R1 = r_regs[REG_R1];
    assign R2 = r_regs[REG_R2];
    assign R3 = r_regs[REG_R3];
    assign R4 = r_regs[REG_R4];
    assign R5 = r_regs[REG_R5];
    assign R6 = r_regs[REG_R6];
    assign R7 = r_regs[REG_R7];

    multiplexer_8_to_1_16_bit u_rd1_mux (
        .I0 (R0), .I1 (R1), .I2 (R2), .I3 (R3),
        .I4 (R4), .I5 (R5), .I6 (R6), .I7 (R7),
        .S2 (RA1[2]), .S1 (RA1[1]), .S0 (RA1[0]),
        .Y  (w_rd1_raw)
    );

    multiplexer_8_to_1_16_bit u_rd2_mux (
        .I0 (R0), .I1 (R1), .I2 (R2), .I3 (R3),
        .I4 (R4), .I5 (R5), .I6 (R6), .I7 (R7),
        .S2 (RA2[2]), .S1 (RA2[1]), .S0 (RA2[0]),
        .Y  (w_rd2_raw)
    );

    // Bypass only when the pending write will actually land; the decode already excludes R0 drops
    assign w_byp1 = WRITE_THROUGH && !RST && w_wr_dec[WA] && (WA == RA1);
    assign w_byp2 = WRITE_THROUGH && !RST && w_wr_dec[WA] && (WA == RA2);

    assign RD1 = w_byp1 ? WD : w_rd1_raw;
    assign RD2 = w_byp2 ? WD : w_rd2_raw;

endmodule

// File: tb/tb_register_file_8x16_bit.sv
// tb/tb_register_file_8x16_bit.sv - scoreboard bench for two register file configurations
module tb_register_file_8x16_bit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WE;
    logic [2:0]  WA;
    logic [15:0] WD;
    logic [2:0]  RA1;
    logic [2:0]  RA2;

    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic [15:0] a_r [8];
    logic [15:0] b_r [8];

    logic [15:0] m_a [8];
    logic [15:0] m_b [8];
    logic [15:0] wvals [8];

    typedef struct packed {
        logic [15:0] rd1a;
        logic [15:0] rd2a;
        logic [15:0] rd1b;
        logic [15:0] rd2b;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int checks = 0;
    int failures = 0;

    always #10 CLK = ~CLK;

    register_file_8x16_bit u_dut_a (
        .CLK (CLK), .RST (RST), .WE (WE), .WA (WA), .WD (WD),
        .RA1 (RA1), .RA2 (RA2), .RD1 (a_rd1), .RD2 (a_rd2),
        .R0 (a_r[0]), .R1 (a_r[1]), .R2 (a_r[2]), .R3 (a_r[3]),
        .R4 (a_r[4]), .R5 (a_r[5]), .R6 (a_r[6]), .R7 (a_r[7])
    );

    register_file_8x16_bit #(
        .R0_ZERO       (1'b0),
        .WRITE_THROUGH (1'b1),
        .RESET_VALUE   (16'h5A5A)
    ) u_dut_b (
        .CLK (CLK), .RST (RST), .WE (WE), .WA (WA), .WD (WD),
        .RA1 (RA1), .RA2 (RA2), .RD1 (b_rd1), .RD2 (b_rd2),
        .R0 (b_r[0]), .R1 (b_r[1]), .R2 (b_r[2]), .R3 (b_r[3]),
        .R4 (b_r[4]), .R5 (b_r[5]), .R6 (b_r[6]), .R7 (b_r[7])
    );

    function automatic logic [15:0] exp_a(input logic [2:0] ra);
        return m_a[ra];
    endfunction

    function automatic logic [15:0] exp_b(input logic [2:0] ra);
        if (!RST && WE && (WA == ra)) return WD;
        return m_b[ra];
    endfunction

    task automatic push_reads();
        sb.push_back({exp_a(RA1), exp_a(RA2), exp_b(RA1), exp_b(RA2)});
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_a[i] = 16'h0000;
            m_b[i] = 16'h5A5A;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (!RST && WE) begin
            if (WA != 3'd0) m_a[WA] = WD;
            m_b[WA] = WD;
        end
        #1;
    endtask

    task automatic test_reset();
        WE = 1'b0; WA = 3'd0; WD = 16'h0000; RA1 = 3'd0; RA2 = 3'd0;
        apply_reset();
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_r[i] !== m_a[i] || b_r[i] !== m_b[i]) begin
                failures++;
                $display("FAIL reset_reg%0d: got a=%h b=%h exp a=%h b=%h", i, a_r[i], b_r[i], m_a[i], m_b[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            RA1 = 3'(i); RA2 = 3'(7 - i);
            push_reads();
            #1;
            e = sb.pop_front();
            checks++;
            if ({a_rd1, a_rd2, b_rd1, b_rd2} !== e) begin
                failures++;
                $display("FAIL reset_read ra=%0d: got %h %h %h %h exp %h %h %h %h", i,
                         a_rd1, a_rd2, b_rd1, b_rd2, e.rd1a, e.rd2a, e.rd1b, e.rd2b);
            end
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_write_sweep();
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            WE = 1'b1; WA = 3'(i); WD = wvals[i];
            tick();
        end
        @(negedge CLK);
        WE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            RA1 = 3'(i); RA2 = 3'(i);
            push_reads();
            #1;
            e = sb.pop_front();
            checks++;
            if ({a_rd1, a_rd2, b_rd1, b_rd2} !== e || a_rd1 !== a_rd2) begin
                failures++;
                $display("FAIL sweep_read ra=%0d: got %h %h %h %h exp %h %h %h %h", i,
                         a_rd1, a_rd2, b_rd1, b_rd2, e.rd1a, e.rd2a, e.rd1b, e.rd2b);
            end
        end
        checks++;
        if (a_r[0] !== 16'h0000 || b_r[0] !== 16'h00DE || a_r[7] !== 16'h00F0) begin
            failures++;
            $display("FAIL sweep_r0: got a_r0=%h b_r0=%h a_r7=%h exp 0000 00de 00f0", a_r[0], b_r[0], a_r[7]);
        end
    endtask

    task automatic test_reset_pulse();
        @(negedge CLK);
        WE = 1'b0;
        apply_reset();
        #1;
        checks++;
        if ({a_r[0], a_r[1], a_r[2], a_r[3], a_r[4], a_r[5], a_r[6], a_r[7]} !== 128'h0) begin
            failures++;
            $display("FAIL pulse_regs: got %h %h %h %h %h %h %h %h exp all 0000",
                     a_r[0], a_r[1], a_r[2], a_r[3], a_r[4], a_r[5], a_r[6], a_r[7]);
        end
        for (int i = 0; i < 8; i++) begin
            RA1 = 3'(i); RA2 = 3'(i);
            push_reads();
            #1;
            e = sb.pop_front();
            checks++;
            if ({a_rd1, a_rd2, b_rd1, b_rd2} !== e) begin
                failures++;
                $display("FAIL pulse_read ra=%0d: got %h %h %h %h exp %h %h %h %h", i,
                         a_rd1, a_rd2, b_rd1, b_rd2, e.rd1a, e.rd2a, e.rd1b, e.rd2b);
            end
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_hold();
        @(negedge CLK);
        WE = 1'b0; WA = 3'd3; WD = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (a_r[i] !== m_a[i] || b_r[i] !== m_b[i]) begin
                    failures++;
                    $display("FAIL hold_reg%0d: got a=%h b=%h exp a=%h b=%h", i, a_r[i], b_r[i], m_a[i], m_b[i]);
                end
            end
        end
        checks++;
        if (a_r[3] !== 16'h0078 || b_r[3] !== 16'h0078) begin
            failures++;
            $display("FAIL hold_r3: got a=%h b=%h exp 0078", a_r[3], b_r[3]);
        end
    endtask

    task automatic test_bypass();
        @(negedge CLK);
        WE = 1'b1; WA = 3'd5; WD = 16'hA5A5; RA1 = 3'd5; RA2 = 3'd6;
        push_reads();
        #1;
        e = sb.pop_front();
        checks++;
        if ({a_rd1, a_rd2, b_rd1, b_rd2} !== e) begin
            failures++;
            $display("FAIL bypass_pre: got %h %h %h %h exp %h %h %h %h",
                     a_rd1, a_rd2, b_rd1, b_rd2, e.rd1a, e.rd2a, e.rd1b, e.rd2b);
        end
        checks++;
        if (a_rd1 !== 16'h0034 || b_rd1 !== 16'hA5A5 || b_rd2 !== 16'h0012) begin
            failures++;
            $display("FAIL bypass_const: got a_rd1=%h b_rd1=%h b_rd2=%h exp 0034 a5a5 0012", a_rd1, b_rd1, b_rd2);
        end
        RA2 = 3'd5;
        #1;
        checks++;
        if (b_rd1 !== 16'hA5A5 || b_rd2 !== 16'hA5A5 || a_rd2 !== 16'h0034) begin
            failures++;
            $display("FAIL bypass_both: got b_rd1=%h b_rd2=%h a_rd2=%h exp a5a5 a5a5 0034", b_rd1, b_rd2, a_rd2);
        end
        tick();
        push_reads();
        #1;
        e = sb.pop_front();
        checks++;
        if ({a_rd1, a_rd2, b_rd1, b_rd2} !== e || a_rd1 !== 16'hA5A5) begin
            failures++;
            $display("FAIL bypass_post: got %h %h %h %h exp %h %h %h %h",
                     a_rd1, a_rd2, b_rd1, b_rd2, e.rd1a, e.rd2a, e.rd1b, e.rd2b);
        end
        WE = 1'b0;
    endtask

    task automatic test_reset_vs_write();
        @(negedge CLK);
        WE = 1'b1; WA = 3'd2; WD = 16'h1234; RA1 = 3'd2; RA2 = 3'd2;
        #9;
        apply_reset();
        tick();
        checks++;
        if (a_r[2] !== 16'h0000 || b_r[2] !== 16'h5A5A) begin
            failures++;
            $display("FAIL rst_wins: got a=%h b=%h exp 0000 5a5a", a_r[2], b_r[2]);
        end
        push_reads();
        #1;
        e = sb.pop_front();
        checks++;
        if ({a_rd1, a_rd2, b_rd1, b_rd2} !== e) begin
            failures++;
            $display("FAIL rst_read: got %h %h %h %h exp %h %h %h %h",
                     a_rd1, a_rd2, b_rd1, b_rd2, e.rd1a, e.rd2a, e.rd1b, e.rd2b);
        end
        @(negedge CLK);
        RST = 1'b0;
        tick();
        checks++;
        if (a_r[2] !== 16'h1234 || b_r[2] !== 16'h1234) begin
            failures++;
            $display("FAIL rst_release_write: got a=%h b=%h exp 1234", a_r[2], b_r[2]);
        end
        WE = 1'b0;
    endtask

    task automatic test_r0_discard();
        @(negedge CLK);
        WE = 1'b1; WA = 3'd0; WD = 16'hBEEF; RA1 = 3'd0; RA2 = 3'd1;
        push_reads();
        #1;
        e = sb.pop_front();
        checks++;
        if ({a_rd1, a_rd2, b_rd1, b_rd2} !== e || a_rd1 !== 16'h0000) begin
            failures++;
            $display("FAIL r0_pre: got %h %h %h %h exp %h %h %h %h",
                     a_rd1, a_rd2, b_rd1, b_rd2, e.rd1a, e.rd2a, e.rd1b, e.rd2b);
        end
        tick();
        WE = 1'b0;
        push_reads();
        #1;
        e = sb.pop_front();
        checks++;
        if ({a_rd1, a_rd2, b_rd1, b_rd2} !== e) begin
            failures++;
            $display("FAIL r0_post: got %h %h %h %h exp %h %h %h %h",
                     a_rd1, a_rd2, b_rd1, b_rd2, e.rd1a, e.rd2a, e.rd1b, e.rd2b);
        end
        checks++;
        if (a_r[0] !== 16'h0000 || b_r[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL r0_store: got a=%h b=%h exp 0000 beef", a_r[0], b_r[0]);
        end
    endtask

    initial begin
        wvals = '{16'h00DE, 16'h00BC, 16'h009A, 16'h0078, 16'h0056, 16'h0034, 16'h0012, 16'h00F0};
        test_reset();
        test_write_sweep();
        test_reset_pulse();
        test_write_sweep();
        test_hold();
        test_bypass();
        test_reset_vs_write();
        test_r0_discard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
